// File: rtl/qram_access_controller_if.sv
// Bundle of the host request/response handshakes and the QRAM pin group for
// qram_access_controller.
//   Request : ReqValid/ReqReady, ReqWrite, ReqAddr[ADDR_W], ReqData
//   Response: RspValid/RspReady, RspData, RspWasWrite
//   QRAM    : QRead, QWrite, QAddressQBit, QDataOut, QDataIn, QDDRClockP/N
//   Status  : Busy
// modport slave is the controller; modport master is everything around it
// (host logic plus the QRAM macro that drives QDataIn).
interface qram_access_controller_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              ReqValid;
    logic              ReqReady;
    logic              ReqWrite;
    logic [ADDR_W-1:0] ReqAddr;
    logic              ReqData;
    logic              RspValid;
    logic              RspReady;
    logic              RspData;
    logic              RspWasWrite;
    logic              QRead;
    logic              QWrite;
    logic              QAddressQBit;
    logic              QDataOut;
    logic              QDataIn;
    logic              QDDRClockP;
    logic              QDDRClockN;
    logic              Busy;

    modport master (
        output ReqValid, ReqWrite, ReqAddr, ReqData, RspReady, QDataIn,
        input  ReqReady, RspValid, RspData, RspWasWrite, QRead, QWrite,
               QAddressQBit, QDataOut, QDDRClockP, QDDRClockN, Busy
    );

    modport slave (
        input  ReqValid, ReqWrite, ReqAddr, ReqData, RspReady, QDataIn,
        output ReqReady, RspValid, RspData, RspWasWrite, QRead, QWrite,
               QAddressQBit, QDataOut, QDDRClockP, QDDRClockN, Busy
    );
endinterface

// File: rtl/qram_access_controller.sv
// Host-side initiator for the bit-serial QRAM_inSDRAM interface.
// Takes one single-bit read/write request at a time, shifts the address out
// MSB first on QAddressQBit, issues a one-cycle Read/Write strobe, waits
// READ_LATENCY cycles for read data, then presents a response.
//   Clock  : rising-edge block clock
//   ResetN : asynchronous active-low reset
//   bus    : qram_access_controller_if.slave (request, response, QRAM pins, Busy)
// Every Q* and Rsp* output comes straight from a flop.
module qram_access_controller #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned READ_LATENCY = 2
) (
    input logic                     Clock,
    input logic                     ResetN,
    qram_access_controller_if.slave bus
);
    localparam int unsigned CNT_W = (ADDR_W > 1) ? $clog2(ADDR_W) : 1;

    typedef enum logic [2:0] {StIdle, StAddr, StCmd, StWait, StResp} stateT;

    stateT             stateQ, stateD;
    logic [CNT_W-1:0]  bitCntQ, bitCntD;
    logic [ADDR_W-1:0] addrQ, addrD;
    logic              writeQ, writeD;
    logic              dataQ, dataD;
    logic [3:0]        waitCntQ, waitCntD;
    logic              rspValidQ, rspValidD;
    logic              rspDataQ, rspDataD;
    logic              rspWasWriteQ, rspWasWriteD;
    logic              qReadQ, qReadD;
    logic              qWriteQ, qWriteD;
    logic              qAddrQ, qAddrD;
    logic              qDataOutQ, qDataOutD;
    logic              ddrPQ, ddrPD;

    always_comb begin
        stateD       = stateQ;
        bitCntD      = bitCntQ;
        addrD        = addrQ;
        writeD       = writeQ;
        dataD        = dataQ;
        waitCntD     = waitCntQ;
        rspValidD    = rspValidQ;
        rspDataD     = rspDataQ;
        rspWasWriteD = rspWasWriteQ;
        qReadD       = 1'b0;
        qWriteD      = 1'b0;
        qAddrD       = 1'b0;
        qDataOutD    = 1'b0;

        unique case (stateQ)
            StIdle: begin
                if (bus.ReqValid) begin
                    stateD  = StAddr;
                    addrD   = bus.ReqAddr;
                    writeD  = bus.ReqWrite;
                    dataD   = bus.ReqData;
                    bitCntD = CNT_W'(ADDR_W - 1);
                    // MSB goes out in the very first ADDR cycle
                    qAddrD  = bus.ReqAddr[ADDR_W-1];
                end
            end
            StAddr: begin
                if (bitCntQ == '0) begin
                    stateD    = StCmd;
                    qWriteD   = writeQ;
                    qReadD    = ~writeQ;
                    qDataOutD = writeQ & dataQ;
                end else begin
                    bitCntD = bitCntQ - CNT_W'(1);
                    qAddrD  = addrQ[bitCntD];
                end
            end
            StCmd: begin
                if (writeQ) begin
                    stateD       = StResp;
                    rspValidD    = 1'b1;
                    rspDataD     = 1'b0;
                    rspWasWriteD = 1'b1;
                end else begin
                    stateD   = StWait;
                    waitCntD = 4'(READ_LATENCY);
                end
            end
            StWait: begin
                if (waitCntQ == 4'd1) begin
                    stateD       = StResp;
                    waitCntD     = 4'd0;
                    rspValidD    = 1'b1;
                    rspDataD     = bus.QDataIn;
                    rspWasWriteD = 1'b0;
                end else begin
                    waitCntD = waitCntQ - 4'd1;
                end
            end
            StResp: begin
                if (bus.RspReady) begin
                    stateD    = StIdle;
                    rspValidD = 1'b0;
                end
            end
            default: stateD = StIdle;
        endcase

        // DDR clock runs only between consecutive active states; the accept edge
        // leaves it low and any edge into RESP/IDLE parks it low.
        if ((stateQ inside {StAddr, StCmd, StWait}) && (stateD inside {StAddr, StCmd, StWait})) begin
            ddrPD = ~ddrPQ;
        end else begin
            ddrPD = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            stateQ       <= StIdle;
            bitCntQ      <= '0;
            addrQ        <= '0;
            writeQ       <= 1'b0;
            dataQ        <= 1'b0;
            waitCntQ     <= 4'd0;
            rspValidQ    <= 1'b0;
            rspDataQ     <= 1'b0;
            rspWasWriteQ <= 1'b0;
            qReadQ       <= 1'b0;
            qWriteQ      <= 1'b0;
            qAddrQ       <= 1'b0;
            qDataOutQ    <= 1'b0;
            ddrPQ        <= 1'b0;
        end else begin
            stateQ       <= stateD;
            bitCntQ      <= bitCntD;
            addrQ        <= addrD;
            writeQ       <= writeD;
            dataQ        <= dataD;
            waitCntQ     <= waitCntD;
            rspValidQ    <= rspValidD;
            rspDataQ     <= rspDataD;
            rspWasWriteQ <= rspWasWriteD;
            qReadQ       <= qReadD;
            qWriteQ      <= qWriteD;
            qAddrQ       <= qAddrD;
            qDataOutQ    <= qDataOutD;
            ddrPQ        <= ddrPD;
        end
    end

    assign bus.ReqReady     = (stateQ == StIdle);
    assign bus.Busy         = (stateQ != StIdle);
    assign bus.RspValid     = rspValidQ;
    assign bus.RspData      = rspDataQ;
    assign bus.RspWasWrite  = rspWasWriteQ;
    assign bus.QRead        = qReadQ;
    assign bus.QWrite       = qWriteQ;
    assign bus.QAddressQBit = qAddrQ;
    assign bus.QDataOut     = qDataOutQ;
    assign bus.QDDRClockP   = ddrPQ;
    assign bus.QDDRClockN   = ~ddrPQ;
endmodule

// File: tb/tb_qram_access_controller.sv
// Self-checking bench for qram_access_controller: a transaction-level model
// predicts every output each cycle from cycles-since-accept arithmetic, a table
// of directed transactions checks latency/data/serial address, and hand
// sequences cover back-to-back requests and reset mid-transaction.
module tb_qram_access_controller;
    localparam int AW = 8;
    localparam int RL = 2;

    logic Clock = 1'b0;
    logic ResetN;

    qram_access_controller_if #(.ADDR_W(AW)) bus ();

    qram_access_controller #(
        .ADDR_W      (AW),
        .READ_LATENCY(RL)
    ) dut (
        .Clock (Clock),
        .ResetN(ResetN),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    int vectors     = 0;
    int miscompares = 0;
    int cycleNo     = 0;

    // Model: phase 0 = idle, otherwise cycles since the accept edge.
    int          phase;
    bit          inResp;
    bit          mWrite;
    bit          mData;
    logic [AW-1:0] mAddr;
    bit          lastRspData;
    bit          lastRspWasWrite;
    bit          mem [256];

    typedef struct {
        bit         isWrite;
        logic [7:0] addr;
        bit         data;
        int         hold;
        bit         expData;
        bit         expWasWrite;
        int         expLat;
    } TxnVec;

    TxnVec vecs [9];

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cycleNo, act, exp);
        end
    endfunction

    function automatic int respStart();
        return AW + 2 + (mWrite ? 0 : RL);
    endfunction

    function automatic void modelReset();
        phase           = 0;
        inResp          = 1'b0;
        lastRspData     = 1'b0;
        lastRspWasWrite = 1'b0;
    endfunction

    function automatic void modelAdvance();
        if (inResp) begin
            if (bus.RspReady) begin
                inResp = 1'b0;
                phase  = 0;
            end
        end else if (phase == 0) begin
            if (bus.ReqValid) begin
                mWrite = bus.ReqWrite;
                mAddr  = bus.ReqAddr;
                mData  = bus.ReqData;
                phase  = 1;
            end
        end else begin
            phase++;
            if (phase == respStart()) begin
                inResp          = 1'b1;
                lastRspWasWrite = mWrite;
                if (mWrite) begin
                    mem[mAddr]  = mData;
                    lastRspData = 1'b0;
                end else begin
                    lastRspData = mem[mAddr];
                end
            end
        end
    endfunction

    // QRAM stand-in: true data only in the cycle READ_LATENCY after the strobe,
    // the inverted bit in the other cycles of a read.
    function automatic void driveQDataIn();
        if (phase > 0 && !inResp && !mWrite) begin
            bus.QDataIn = (phase == AW + 1 + RL) ? mem[mAddr] : ~mem[mAddr];
        end else begin
            bus.QDataIn = 1'($urandom);
        end
    endfunction

    function automatic void checkAll();
        bit busy   = (phase > 0) && !inResp;
        bit strobe = busy && (phase == AW + 1);
        bit expP   = busy ? bit'((phase - 1) % 2) : 1'b0;
        chk("ReqReady", bus.ReqReady, phase == 0);
        chk("Busy", bus.Busy, phase != 0);
        chk("QAddressQBit", bus.QAddressQBit, (busy && phase <= AW) ? mAddr[AW-phase] : 1'b0);
        chk("QWrite", bus.QWrite, strobe && mWrite);
        chk("QRead", bus.QRead, strobe && !mWrite);
        chk("QDataOut", bus.QDataOut, strobe && mWrite && mData);
        chk("QDDRClockP", bus.QDDRClockP, expP);
        chk("QDDRClockN", bus.QDDRClockN, !expP);
        chk("RspValid", bus.RspValid, inResp);
        chk("RspData", bus.RspData, lastRspData);
        chk("RspWasWrite", bus.RspWasWrite, lastRspWasWrite);
    endfunction

    task automatic tick();
        modelAdvance();
        @(posedge Clock);
        #1;
        cycleNo++;
        driveQDataIn();
        checkAll();
    endtask

    task automatic pulseReset();
        ResetN = 1'b0;
        #2;
        modelReset();
        driveQDataIn();
        checkAll();
        @(negedge Clock);
        ResetN = 1'b1;
    endtask

    task automatic runTxn(input TxnVec v);
        int         lat;
        bit         seen;
        int         strobeCyc;
        logic [7:0] serial;
        chk("ready before request", bus.ReqReady, 1'b1);
        bus.ReqValid = 1'b1;
        bus.ReqWrite = v.isWrite;
        bus.ReqAddr  = v.addr;
        bus.ReqData  = v.data;
        bus.RspReady = (v.hold == 0);
        tick();
        bus.ReqValid = 1'b0;
        lat       = 1;
        seen      = bus.RspValid;
        strobeCyc = 0;
        serial    = {7'd0, bus.QAddressQBit};
        for (int i = 0; i < 40 && !seen; i++) begin
            bus.ReqWrite = 1'($urandom);
            bus.ReqAddr  = 8'($urandom);
            bus.ReqData  = 1'($urandom);
            tick();
            lat++;
            if (lat <= AW) serial = {serial[6:0], bus.QAddressQBit};
            if ((bus.QRead || bus.QWrite) && strobeCyc == 0) strobeCyc = lat;
            seen = bus.RspValid;
        end
        chk("serial address", serial, v.addr);
        chk("strobe cycle", strobeCyc, AW + 1);
        chk("response latency", lat, v.expLat);
        chk("response data", bus.RspData, v.expData);
        chk("response kind", bus.RspWasWrite, v.expWasWrite);
        for (int h = 0; h < v.hold; h++) begin
            bus.ReqValid = 1'($urandom);
            bus.ReqWrite = 1'($urandom);
            bus.ReqAddr  = 8'($urandom);
            bus.ReqData  = 1'($urandom);
            tick();
            chk("held RspValid", bus.RspValid, 1'b1);
            chk("held RspData", bus.RspData, v.expData);
            chk("ReqReady while held", bus.ReqReady, 1'b0);
        end
        bus.ReqValid = 1'b0;
        bus.RspReady = 1'b1;
        tick();
        chk("response released", bus.RspValid, 1'b0);
        chk("idle after response", bus.ReqReady, 1'b1);
    endtask

    initial begin
        bit sawWrite;
        vecs[0] = '{1'b1, 8'hA5, 1'b1, 0, 1'b0, 1'b1, AW + 2};
        vecs[1] = '{1'b0, 8'hA5, 1'b0, 0, 1'b1, 1'b0, AW + 2 + RL};
        vecs[2] = '{1'b1, 8'h3C, 1'b1, 0, 1'b0, 1'b1, AW + 2};
        vecs[3] = '{1'b0, 8'h3C, 1'b0, 5, 1'b1, 1'b0, AW + 2 + RL};
        vecs[4] = '{1'b0, 8'h01, 1'b0, 0, 1'b0, 1'b0, AW + 2 + RL};
        vecs[5] = '{1'b1, 8'h01, 1'b1, 2, 1'b0, 1'b1, AW + 2};
        vecs[6] = '{1'b0, 8'h01, 1'b0, 1, 1'b1, 1'b0, AW + 2 + RL};
        vecs[7] = '{1'b1, 8'hA5, 1'b0, 0, 1'b0, 1'b1, AW + 2};
        vecs[8] = '{1'b0, 8'hA5, 1'b0, 3, 1'b0, 1'b0, AW + 2 + RL};
        for (int i = 0; i < 256; i++) mem[i] = 1'b0;

        bus.ReqValid = 1'b0;
        bus.ReqWrite = 1'b0;
        bus.ReqAddr  = '0;
        bus.ReqData  = 1'b0;
        bus.RspReady = 1'b0;
        bus.QDataIn  = 1'b0;
        ResetN       = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        modelReset();
        checkAll();
        @(negedge Clock);
        ResetN = 1'b1;

        // Idle with no requests
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle ReqReady", bus.ReqReady, 1'b1);
            chk("idle QDDRClockN", bus.QDDRClockN, 1'b1);
        end

        foreach (vecs[i]) runTxn(vecs[i]);

        // Back-to-back: ReqValid held, second request only after the handshake
        bus.ReqValid = 1'b1;
        bus.ReqWrite = 1'b1;
        bus.ReqAddr  = 8'hA5;
        bus.ReqData  = 1'b1;
        bus.RspReady = 1'b1;
        tick();
        bus.ReqWrite = 1'b0;
        bus.ReqAddr  = 8'h01;
        for (int c = 2; c <= AW + 3; c++) begin
            tick();
            chk("b2b ReqReady", bus.ReqReady, c == AW + 3);
        end
        tick();
        chk("b2b second accepted", bus.Busy, 1'b1);
        bus.ReqValid = 1'b0;
        for (int i = 0; i < 30 && !bus.ReqReady; i++) tick();
        chk("b2b drained", bus.ReqReady, 1'b1);

        // Reset in cycle 4 of a write aborts it
        bus.ReqValid = 1'b1;
        bus.ReqWrite = 1'b1;
        bus.ReqAddr  = 8'h3C;
        bus.ReqData  = 1'b0;
        tick();
        bus.ReqValid = 1'b0;
        sawWrite = 1'b0;
        repeat (3) begin
            tick();
            sawWrite |= bus.QWrite;
        end
        pulseReset();
        for (int i = 0; i < 15; i++) begin
            tick();
            sawWrite |= bus.QWrite | bus.RspValid;
        end
        chk("aborted write silent", sawWrite, 1'b0);
        runTxn('{1'b0, 8'h3C, 1'b0, 0, 1'b1, 1'b0, AW + 2 + RL});
        runTxn('{1'b1, 8'h3C, 1'b0, 0, 1'b0, 1'b1, AW + 2});

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            bus.ReqValid = ($urandom_range(0, 2) == 0);
            bus.ReqWrite = 1'($urandom);
            case ($urandom_range(0, 3))
                0: bus.ReqAddr = 8'hA5;
                1: bus.ReqAddr = 8'h3C;
                2: bus.ReqAddr = 8'h01;
                default: bus.ReqAddr = 8'hFF;
            endcase
            bus.ReqData  = 1'($urandom);
            bus.RspReady = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/qram_access_controller.md
Name: qram_access_controller

Overview:
- Host-side initiator for the QRAM_inSDRAM bit-serial QRAM interface; drives the pins that device receives (Read, Write, AddressQBit, inputQBit, DDRClockP/N) and samples its outputQBit.
- Accepts single-bit read/write requests over a valid/ready handshake and serialises the address onto the 1-bit address line.
- Runs the command sequence, then returns a response over a second valid/ready handshake.
- Sits between IC-level logic and the QRAM macro. One request outstanding at a time.

Parameters:
- ADDR_W, 8, address width in bits; shifted out MSB first. Legal range 1..32.
- READ_LATENCY, 2, Clock cycles from the read strobe cycle to valid QDataIn. Legal range 1..15.

Ports:
- Clock  input  1  single block clock; all state updates on the rising edge.
- ResetN  input  1  asynchronous active-low reset.
- ReqValid  input  1  host request valid.
- ReqReady  output  1  controller can accept a request. High only in IDLE.
- ReqWrite  input  1  1 = write, 0 = read.
- ReqAddr  input  ADDR_W  QRAM bit address.
- ReqData  input  1  write data bit.
- RspValid  output  1  response valid.
- RspReady  input  1  host accepts the response.
- RspData  output  1  read data bit; 0 for writes.
- RspWasWrite  output  1  response belongs to a write.
- QRead  output  1  to QRAM Read.
- QWrite  output  1  to QRAM Write.
- QAddressQBit  output  1  serial address to QRAM AddressQBit.
- QDataOut  output  1  to QRAM inputQBit.
- QDataIn  input  1  from QRAM outputQBit.
- QDDRClockP  output  1  QRAM DDR clock, true phase.
- QDDRClockN  output  1  QRAM DDR clock, complement; always equal to ~QDDRClockP.
- Busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values (async, ResetN=0): state=IDLE.
  - ReqReady=1.
  - RspValid=0, RspData=0, RspWasWrite=0.
  - QRead=0, QWrite=0, QAddressQBit=0, QDataOut=0.
  - QDDRClockP=0, QDDRClockN=1.
  - Busy=0. Internal counters and shift register = 0.
- Reset asserted mid-operation aborts the transaction immediately. No strobe may stay high and no response is produced. The first cycle after deassertion is IDLE.
- All Q* outputs and Rsp* outputs are registered (no combinational path from inputs).
- IDLE:
  - Accept on an edge with ReqValid=1 (ReqReady=1). Capture ReqAddr, ReqWrite and ReqData. Load bit counter = ADDR_W-1. Go to ADDR.
  - No ReqValid: remain in IDLE.
- ADDR:
  - Lasts exactly ADDR_W cycles. QAddressQBit = captured address bit [counter], MSB first.
  - Counter decrements each cycle; at 0 go to CMD.
- CMD:
  - Lasts exactly 1 cycle. QAddressQBit=0.
  - Write: QWrite=1 and QDataOut=captured data; next state RESP with RspWasWrite=1, RspData=0.
  - Read: QRead=1, QDataOut=0; load wait counter = READ_LATENCY; go to WAIT.
- WAIT (read only):
  - Lasts READ_LATENCY cycles; all strobes are 0.
  - On the edge ending the last WAIT cycle, capture QDataIn into RspData, set RspWasWrite=0 and go to RESP.
- RESP:
  - RspValid=1, held stable with RspData and RspWasWrite until an edge with RspReady=1.
  - On that edge: RspValid goes to 0 and state goes to IDLE.
  - If RspReady is already high, RspValid is high for exactly 1 cycle.
  - A new request cannot be accepted in the same edge as the response (ReqReady=0 in RESP).
- DDR clock:
  - QDDRClockP toggles every Clock edge while in ADDR, CMD or WAIT.
  - It is forced to 0 on the edge entering RESP or IDLE. QDDRClockN = ~QDDRClockP at all times.
- Latency, counting the accept edge as cycle 0:
  - The address occupies cycles 1..ADDR_W.
  - The strobe is in cycle ADDR_W+1.
  - Write RspValid first appears in cycle ADDR_W+2.
  - Read RspValid first appears in cycle ADDR_W+2+READ_LATENCY.
- Changes to the Req* inputs after acceptance have no effect on the transaction in flight.

Test Plan:
- Reset, then ReqValid held 0 for 10 cycles -> ReqReady=1, Busy=0, QRead/QWrite=0, QDDRClockP=0, QDDRClockN=1, RspValid=0 throughout.
- Write with Addr=8'hA5, Data=1, RspReady=1 -> QAddressQBit=1,0,1,0,0,1,0,1 in cycles 1..8. QWrite=1 and QDataOut=1 only in cycle 9. RspValid=1 with RspWasWrite=1 only in cycle 10. ReqReady=1 in cycle 11.
- Read with Addr=8'h3C, QRAM model returning 1 exactly 2 cycles after QRead -> QRead=1 in cycle 9. RspValid in cycle 12 with RspData=1, RspWasWrite=0.
- Read with RspReady held 0 for 5 cycles after RspValid, Req* changed meanwhile -> RspValid and RspData stable for all 5 cycles, ReqReady=0. Single response on release.
- Back-to-back requests (ReqValid held 1, second Addr=8'h01) -> the second request is accepted only in the cycle after the first response handshake. There is no overlap of QAddressQBit or strobes.
- ResetN pulsed low in cycle 4 of a write -> QWrite is never asserted and no RspValid appears. IDLE with reset values follows, and the next write completes normally.
